// File: rtl/keccak_round_ctrl.sv
// rtl/keccak_round_ctrl.sv - round sequencer for the Keccak-p permutation core
//
// Start/busy/done FSM with a round counter, run-time round count, stall and
// abort control. Drives the round datapath enable, round-constant index and
// first/last round flags.
//
// Optional status block: define KECCAK_ROUND_CTRL_STATUS_EN to add the
// stall_cnt and err_start_busy outputs.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          begin a permutation (accepted in IDLE or DONE)
//   rounds_cfg     rounds for this run, sampled on an accepted start
//   stall          hold the current round
//   abort          cancel the run, return to IDLE
//   busy           high while rounds are being applied
//   round_en       datapath applies one round this cycle
//   round_num      current round index 0 .. cfg-1
//   rc_idx         round-constant index NUM_ROUNDS - cfg + round_num
//   round_first    round_en on round 0
//   round_last     round_en on round cfg-1
//   stall_cnt      (status build) stall cycles of the current/last run
//   err_start_busy (status build) sticky: start seen while running
//   done           one-cycle pulse after the last round

module keccak_round_ctrl #(
    parameter int NUM_ROUNDS = 24,
    parameter int CNT_W      = $clog2(NUM_ROUNDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] rounds_cfg,
    input  logic             stall,
    input  logic             abort,
    output logic             busy,
    output logic             round_en,
    output logic [CNT_W-1:0] round_num,
    output logic [CNT_W-1:0] rc_idx,
    output logic             round_first,
    output logic             round_last,
`ifdef KECCAK_ROUND_CTRL_STATUS_EN
    output logic [15:0]      stall_cnt,
    output logic [0:0]       err_start_busy,
`endif
    output logic             done
);

    localparam logic [CNT_W-1:0] NR = CNT_W'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] cfg, cfg_next;
    logic [CNT_W-1:0] cfg_eff;
    logic             start_accept;
    logic             is_last;

    // Out-of-range round counts are clamped to a full permutation.
    assign cfg_eff = (rounds_cfg == '0 || rounds_cfg > NR) ? NR : rounds_cfg;

    assign start_accept = start && !abort && (state == S_IDLE || state == S_DONE);
    assign is_last      = (cnt == cfg - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            cfg   <= NR;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cfg   <= cfg_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cfg_next   = cfg;
        if (abort) begin
            // Abort wins over everything, including the final round: no done.
            state_next = S_IDLE;
            cnt_next   = '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    cnt_next = '0;
                    if (start) begin
                        state_next = S_RUN;
                        cfg_next   = cfg_eff;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (is_last) begin
                            state_next = S_DONE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign busy        = (state == S_RUN);
    assign done        = (state == S_DONE);
    assign round_num   = cnt;
    assign round_en    = busy && !stall;
    assign round_first = round_en && (cnt == '0);
    assign round_last  = round_en && is_last;
    assign rc_idx      = busy ? (NR - cfg + cnt) : '0;

`ifdef KECCAK_ROUND_CTRL_STATUS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt      <= '0;
            err_start_busy <= 1'b0;
        end else begin
            if (start_accept) begin
                stall_cnt <= '0;
            end else if (busy && stall && !abort && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (busy && start) begin
                err_start_busy <= 1'b1;
            end
        end
    end
`else
    // start_accept only feeds the status block.
    logic unused_ok;
    assign unused_ok = start_accept;
`endif

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// tb/tb_keccak_round_ctrl.sv - directed self-checking bench for keccak_round_ctrl

module tb_keccak_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] rounds_cfg = '0;
    logic       stall = 1'b0;
    logic       abort = 1'b0;
    logic       busy, round_en, round_first, round_last, done;
    logic [4:0] round_num, rc_idx;
`ifdef KECCAK_ROUND_CTRL_STATUS_EN
    logic [15:0] stall_cnt;
    logic [0:0]  err_start_busy;
`endif

    int checks = 0;
    int errors = 0;

    keccak_round_ctrl #(.NUM_ROUNDS(24)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rounds_cfg  (rounds_cfg),
        .stall       (stall),
        .abort       (abort),
        .busy        (busy),
        .round_en    (round_en),
        .round_num   (round_num),
        .rc_idx      (rc_idx),
        .round_first (round_first),
        .round_last  (round_last),
`ifdef KECCAK_ROUND_CTRL_STATUS_EN
        .stall_cnt      (stall_cnt),
        .err_start_busy (err_start_busy),
`endif
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run and walk it cycle by cycle. n is the hand-computed effective
    // round count; an optional stall of stall_len cycles is inserted at round
    // stall_at (stall_at < 0 for none).
    task automatic do_run(input int cfg, input int n, input int stall_at, input int stall_len);
        start = 1'b1;
        rounds_cfg = 5'(cfg);
        tick();
        start = 1'b0;
        rounds_cfg = 5'd3;
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                stall = 1'b1;
                for (int s = 0; s < stall_len; s++) begin
                    #1;
                    check("stall_round_num", round_num, i);
                    check("stall_round_en", round_en, 0);
                    check("stall_busy", busy, 1);
                    tick();
                end
                stall = 1'b0;
            end
            #1;
            check("run_busy", busy, 1);
            check("run_round_en", round_en, 1);
            check("run_round_num", round_num, i);
            check("run_rc_idx", rc_idx, 24 - n + i);
            check("run_first", round_first, (i == 0));
            check("run_last", round_last, (i == n - 1));
            check("run_done", done, 0);
            tick();
        end
        #1;
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_round_num", round_num, 0);
        check("end_rc_idx", rc_idx, 0);
        tick();
        #1;
        check("after_done", done, 0);
        check("after_busy", busy, 0);
    endtask

    initial begin
        // reset state
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_round_en", round_en, 0);
        check("rst_round_num", round_num, 0);
        check("rst_rc_idx", rc_idx, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // full run, reduced run, clamped run
        do_run(0, 24, -1, 0);
        do_run(12, 12, -1, 0);
        do_run(30, 24, -1, 0);

        // stall at round 5 for 3 cycles
        do_run(24, 24, 5, 3);
`ifdef KECCAK_ROUND_CTRL_STATUS_EN
        check("stall_cnt", stall_cnt, 3);
        check("err_clear", err_start_busy, 0);
`endif

        // start while running is ignored, then abort at round 10
        start = 1'b1;
        rounds_cfg = 5'd0;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        start = 1'b1;
        rounds_cfg = 5'd5;
        #1;
        check("ign_round_num", round_num, 3);
        tick();
        start = 1'b0;
        #1;
        check("ign_round_num_next", round_num, 4);
        check("ign_rc_idx", rc_idx, 4);
        check("ign_busy", busy, 1);
`ifdef KECCAK_ROUND_CTRL_STATUS_EN
        check("stall_cnt_cleared", stall_cnt, 0);
        check("err_start_busy", err_start_busy, 1);
`endif
        for (int k = 0; k < 6; k++) tick();
        check("abort_at", round_num, 10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_round_num", round_num, 0);
        check("abort_done", done, 0);
        check("abort_round_en", round_en, 0);
        tick();
        check("abort_no_done", done, 0);

        // abort on the last round suppresses done
        start = 1'b1;
        rounds_cfg = 5'd2;
        tick();
        start = 1'b0;
        tick();
        #1;
        check("abl_last", round_last, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        check("abl_done", done, 0);
        check("abl_busy", busy, 0);

        // back-to-back: start held through DONE, second run cfg=1
        start = 1'b1;
        rounds_cfg = 5'd3;
        tick();
        tick();
        tick();
        rounds_cfg = 5'd1;
        tick();
        #1;
        check("b2b_done", done, 1);
        tick();
        start = 1'b0;
        #1;
        check("b2b_busy", busy, 1);
        check("b2b_first", round_first, 1);
        check("b2b_last", round_last, 1);
        check("b2b_rc_idx", rc_idx, 23);
        tick();
        check("b2b_done2", done, 1);
        tick();
        check("b2b_idle", busy, 0);

        // asynchronous reset mid-run at round 7
        start = 1'b1;
        rounds_cfg = 5'd0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check("pre_rst_round_num", round_num, 7);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_round_en", round_en, 0);
        check("arst_round_num", round_num, 0);
        check("arst_rc_idx", rc_idx, 0);
        check("arst_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
